// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter: shares the 16-bit SDRAM controller between video refill, cache write-back and cache fill (optional VID_FRAME_SYNC_EN)
module sdram_cmd_arbiter #(
  parameter int VID_LAST       = 19199,
  parameter int VID_BEATS      = 16,
  parameter int LINE_BEATS     = 128,
  parameter int VID_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_req,
  input  logic        cache_wr_req,
  input  logic        cache_rd_req,
  input  logic [16:0] cache_waddr,
  input  logic [16:0] cache_raddr,
  output logic [1:0]  sys_cmd,
  output logic [22:0] sys_addr,
  input  logic [1:0]  sys_cmd_ack,
  input  logic        sys_rd_data_valid,
  input  logic        sys_wr_data_valid,
  input  logic [15:0] sys_dout,
  output logic        cache_write_data,
  output logic        cache_read_data,
  output logic [31:0] vq_data,
  output logic        vq_wren,
  output logic [18:0] vidadr,
  input  logic        vsync,
  output logic        err
);
  localparam int BW = $clog2(LINE_BEATS + 1);
  localparam int SW = $clog2(VID_STREAK_MAX + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;
  typedef enum logic [1:0] {OWN_V, OWN_W, OWN_R} owner_t;
  state_t        state, state_nx;
  owner_t        owner;
  logic [BW-1:0] beats;
  logic [SW-1:0] streak;
  logic [15:0]   held;
  logic [18:0]   vid_cur, vid_next;
  logic          cache_pend, grant_v, grant_w, grant_r, granting;
  logic          ack_seen, beat_ok, last_beat, bad_valid;
`ifdef VID_FRAME_SYNC_EN
  logic [2:0] vs_sh;
  logic       frame_pend;
  // Synchronize vsync and remember a rising edge until the arbiter next sits in IDLE
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      vs_sh      <= '0;
      frame_pend <= 1'b0;
    end else begin
      vs_sh      <= {vs_sh[1:0], vsync};
      frame_pend <= (vs_sh[1] & ~vs_sh[2]) | (frame_pend & (state != IDLE));
    end
  assign vid_cur = frame_pend ? '0 : vidadr;
`else
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign vid_cur = vidadr;
`endif
  assign cache_pend = cache_wr_req | cache_rd_req;
  assign grant_v    = state == IDLE && vid_req && !(streak == SW'(VID_STREAK_MAX) && cache_pend);
  assign grant_w    = state == IDLE && !grant_v && cache_wr_req;
  assign grant_r    = state == IDLE && !grant_v && !cache_wr_req && cache_rd_req;
  assign granting   = grant_v | grant_w | grant_r;
  assign ack_seen   = state == ISSUE && sys_cmd_ack != 2'b00;
  assign beat_ok    = state == XFER && (owner == OWN_W ? sys_wr_data_valid : sys_rd_data_valid);
  assign last_beat  = beat_ok && beats == BW'((owner == OWN_V ? VID_BEATS : LINE_BEATS) - 1);
  assign bad_valid  = state == XFER ? (owner == OWN_W ? sys_rd_data_valid : sys_wr_data_valid)
                                    : (sys_rd_data_valid | sys_wr_data_valid);
  assign vid_next   = vidadr == 19'(VID_LAST) ? '0 : vidadr + 19'd1;
  // Next state: grant leads to ISSUE, ack to XFER, final beat back to IDLE
  always_comb begin
    state_nx = state;
    if (granting) state_nx = ISSUE;
    if (ack_seen) state_nx = XFER;
    if (last_beat) state_nx = IDLE;
  end
  // State register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // Latch owner, command and address on a grant; drop the command once acknowledged
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      owner    <= OWN_V;
      sys_cmd  <= 2'b00;
      sys_addr <= '0;
      beats    <= '0;
    end else begin
      if (granting) begin
        owner    <= grant_v ? OWN_V : grant_w ? OWN_W : OWN_R;
        sys_cmd  <= grant_v ? 2'b10 : grant_w ? 2'b01 : 2'b11;
        sys_addr <= grant_v ? {1'b1, vid_cur, 3'b000} : {grant_w ? cache_waddr : cache_raddr, 6'b0};
        beats    <= '0;
      end
      if (ack_seen) sys_cmd <= 2'b00;
      if (beat_ok) beats <= beats + 1'b1;
    end
  // Count video wins over a waiting cache request so the cache cannot starve
  always_ff @(posedge clk or negedge rst)
    if (!rst) streak <= '0;
    else if (!cache_pend || grant_w || grant_r) streak <= '0;
    else if (grant_v) streak <= streak + 1'b1;
  // Video frame address: apply a pending frame restart in IDLE, advance on video ack
  always_ff @(posedge clk or negedge rst)
    if (!rst) vidadr <= '0;
    else if (ack_seen && owner == OWN_V) vidadr <= vid_next;
    else if (state == IDLE) vidadr <= vid_cur;
  // Route beats: cache strobes and 32-bit video packing, all one cycle after the beat
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cache_write_data <= 1'b0;
      cache_read_data  <= 1'b0;
      vq_wren          <= 1'b0;
      vq_data          <= '0;
      held             <= '0;
    end else begin
      cache_write_data <= beat_ok && owner == OWN_R;
      cache_read_data  <= beat_ok && owner == OWN_W;
      vq_wren          <= beat_ok && owner == OWN_V && beats[0];
      if (beat_ok && owner == OWN_V && beats[0]) vq_data <= {sys_dout, held};
      if (beat_ok && owner == OWN_V && !beats[0]) held <= sys_dout;
    end
  // Sticky protocol error: stray or wrong-type data valid, or ack code not matching the command
  always_ff @(posedge clk or negedge rst)
    if (!rst) err <= 1'b0;
    else if (bad_valid || (ack_seen && sys_cmd_ack != sys_cmd)) err <= 1'b1;
endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// tb_sdram_cmd_arbiter: randomized bench for sdram_cmd_arbiter against a transaction-level model
module tb_sdram_cmd_arbiter;
  localparam int VL = 5;
  logic        clk = 1'b0, rst = 1'b0;
  logic        vid_req = 0, cache_wr_req = 0, cache_rd_req = 0;
  logic [16:0] cache_waddr = '0, cache_raddr = '0;
  logic [1:0]  sys_cmd, sys_cmd_ack = 2'b00;
  logic [22:0] sys_addr;
  logic        sys_rd_data_valid = 0, sys_wr_data_valid = 0;
  logic [15:0] sys_dout = '0;
  logic        cache_write_data, cache_read_data, vq_wren, vsync = 0, err;
  logic [31:0] vq_data;
  logic [18:0] vidadr;
  int tests_run = 0, tests_failed = 0;
  int m_vidadr = 0, m_streak = 0;
  logic m_err = 1'b0;
  int n_cw = 0, n_cr = 0;
  logic [31:0] vq_q[$];

  sdram_cmd_arbiter #(.VID_LAST(VL)) dut (
    .clk(clk), .rst(rst), .vid_req(vid_req), .cache_wr_req(cache_wr_req),
    .cache_rd_req(cache_rd_req), .cache_waddr(cache_waddr), .cache_raddr(cache_raddr),
    .sys_cmd(sys_cmd), .sys_addr(sys_addr), .sys_cmd_ack(sys_cmd_ack),
    .sys_rd_data_valid(sys_rd_data_valid), .sys_wr_data_valid(sys_wr_data_valid),
    .sys_dout(sys_dout), .cache_write_data(cache_write_data), .cache_read_data(cache_read_data),
    .vq_data(vq_data), .vq_wren(vq_wren), .vidadr(vidadr), .vsync(vsync), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cache_write_data) n_cw++;
    if (cache_read_data) n_cr++;
    if (vq_wren) vq_q.push_back(vq_data);
  end

  task automatic run_txn(input bit v, input bit w, input bit r, input bit hold,
                         input bit seq, input int ack_dly, input int abort_at);
    logic [1:0]  ecmd;
    logic [22:0] eaddr;
    logic [15:0] dd;
    logic [15:0] d[$];
    logic [31:0] ev;
    int nb, cw0, cr0, vq0, t, k;
    @(negedge clk);
    vid_req = v; cache_wr_req = w; cache_rd_req = r;
    if (!(w | r)) m_streak = 0;
    if (v && !(m_streak == 4 && (w | r))) begin
      ecmd = 2'b10; eaddr = {1'b1, 19'(m_vidadr), 3'b000};
      if (w | r) m_streak++;
    end else if (w) begin
      ecmd = 2'b01; eaddr = {cache_waddr, 6'b0}; m_streak = 0;
    end else begin
      ecmd = 2'b11; eaddr = {cache_raddr, 6'b0}; m_streak = 0;
    end
    cw0 = n_cw; cr0 = n_cr; vq0 = vq_q.size();
    nb = ecmd == 2'b10 ? 16 : 128;
    t = 0;
    while (sys_cmd == 2'b00 && t < 20) begin @(negedge clk); t++; end
    tests_run++;
    if (sys_cmd !== ecmd || sys_addr !== eaddr) begin
      tests_failed++;
      $display("FAIL grant: cmd=%b addr=%h, expected cmd=%b addr=%h", sys_cmd, sys_addr, ecmd, eaddr);
      vid_req = 0; cache_wr_req = 0; cache_rd_req = 0; m_streak = 0;
      return;
    end
    if (!hold) begin vid_req = 0; cache_wr_req = 0; cache_rd_req = 0; m_streak = 0; end
    repeat (ack_dly < 0 ? $urandom_range(0, 3) : ack_dly) @(negedge clk);
    tests_run++;
    if (sys_cmd !== ecmd || sys_addr !== eaddr) begin
      tests_failed++;
      $display("FAIL cmd_hold: cmd=%b addr=%h, expected cmd=%b addr=%h", sys_cmd, sys_addr, ecmd, eaddr);
    end
    sys_cmd_ack = ecmd;
    @(negedge clk);
    tests_run++;
    if (sys_cmd !== 2'b00) begin
      tests_failed++;
      $display("FAIL cmd_clear: cmd=%b, expected 00", sys_cmd);
    end
    if ($urandom_range(0, 1) == 1) @(negedge clk);
    sys_cmd_ack = 2'b00;
    for (int i = 0; i < nb; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      dd = seq ? 16'(i + 1) : 16'($urandom);
      d.push_back(dd);
      sys_dout = dd;
      if (ecmd == 2'b01) sys_wr_data_valid = 1; else sys_rd_data_valid = 1;
      @(negedge clk);
      sys_wr_data_valid = 0; sys_rd_data_valid = 0;
      tests_run++;
      if (cache_write_data !== (ecmd == 2'b11) || cache_read_data !== (ecmd == 2'b01)) begin
        tests_failed++;
        $display("FAIL strobe beat %0d: cw=%b cr=%b, expected cw=%b cr=%b", i,
                 cache_write_data, cache_read_data, ecmd == 2'b11, ecmd == 2'b01);
      end
      if (i == abort_at) begin
        rst = 0;
        #1;
        tests_run++;
        if (sys_cmd !== 2'b00 || vq_wren !== 1'b0 || vq_data !== 32'h0 || cache_write_data !== 1'b0 ||
            cache_read_data !== 1'b0 || vidadr !== 19'h0 || err !== 1'b0) begin
          tests_failed++;
          $display("FAIL abort_reset: cmd=%b wren=%b vq=%h cw=%b cr=%b vidadr=%0d err=%b, expected all zero",
                   sys_cmd, vq_wren, vq_data, cache_write_data, cache_read_data, vidadr, err);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        m_vidadr = 0; m_streak = 0; m_err = 0;
        return;
      end
    end
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (n_cw - cw0 !== (ecmd == 2'b11 ? 128 : 0) || n_cr - cr0 !== (ecmd == 2'b01 ? 128 : 0) ||
        vq_q.size() - vq0 !== (ecmd == 2'b10 ? 8 : 0)) begin
      tests_failed++;
      $display("FAIL counts cmd=%b: cw=%0d cr=%0d vq=%0d", ecmd, n_cw - cw0, n_cr - cr0, vq_q.size() - vq0);
    end else if (ecmd == 2'b10) begin
      for (k = 0; k < 8; k++) begin
        ev = {d[2*k+1], d[2*k]};
        tests_run++;
        if (vq_q[vq0+k] !== ev) begin
          tests_failed++;
          $display("FAIL vq_data %0d: got %h, expected %h", k, vq_q[vq0+k], ev);
        end
      end
    end
    if (ecmd == 2'b10) m_vidadr = m_vidadr == VL ? 0 : m_vidadr + 1;
    tests_run++;
    if (vidadr !== 19'(m_vidadr) || err !== m_err) begin
      tests_failed++;
      $display("FAIL post_txn: vidadr=%0d err=%b, expected vidadr=%0d err=%b", vidadr, err, m_vidadr, m_err);
    end
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (sys_cmd !== 2'b00 || vidadr !== 19'h0 || vq_wren !== 1'b0 || vq_data !== 32'h0 ||
        cache_write_data !== 1'b0 || cache_read_data !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: cmd=%b vidadr=%0d wren=%b vq=%h cw=%b cr=%b err=%b, expected zeros",
               sys_cmd, vidadr, vq_wren, vq_data, cache_write_data, cache_read_data, err);
    end
    rst = 1;
    @(negedge clk);
    tests_run++;
    if (sys_cmd !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_no_req: cmd=%b, expected 00", sys_cmd);
    end
  endtask

  task automatic test_video();
    int q0;
    q0 = vq_q.size();
    run_txn(1, 0, 0, 0, 1, 3, -1);
    tests_run++;
    if (vq_q.size() <= q0 || vq_q[q0] !== 32'h00020001) begin
      tests_failed++;
      $display("FAIL first_vq: got %h, expected 00020001", vq_q.size() > q0 ? vq_q[q0] : 32'hx);
    end
  endtask

  task automatic test_arbitration();
    cache_waddr = 17'($urandom); cache_raddr = 17'($urandom);
    for (int i = 0; i < 10; i++) run_txn(1, 1, 1, i != 9, 0, -1, -1);
    for (int i = 0; i < 5; i++) run_txn(1, 0, 1, i != 4, 0, -1, -1);
  endtask

  task automatic test_fill();
    cache_raddr = 17'h00123;
    run_txn(0, 0, 1, 0, 0, -1, -1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < VL + 2; i++) run_txn(1, 0, 0, 0, 0, -1, -1);
  endtask

  task automatic test_random();
    logic [2:0] rq;
    for (int i = 0; i < 16; i++) begin
      rq = 3'($urandom_range(1, 7));
      cache_waddr = 17'($urandom); cache_raddr = 17'($urandom);
      run_txn(rq[2], rq[1], rq[0], 0, 0, -1, -1);
    end
  endtask

  task automatic test_err();
    @(negedge clk);
    sys_rd_data_valid = 1;
    @(negedge clk);
    sys_rd_data_valid = 0;
    @(negedge clk);
    m_err = 1;
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_set: err=%b, expected 1", err);
    end
    run_txn(1, 0, 0, 0, 0, -1, -1);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: err=%b, expected 1", err);
    end
  endtask

  task automatic test_reset_mid_xfer();
    cache_raddr = 17'($urandom);
    run_txn(0, 0, 1, 0, 0, -1, 50);
    run_txn(1, 0, 0, 0, 0, -1, -1);
  endtask

`ifdef VID_FRAME_SYNC_EN
  task automatic test_frame_sync();
    run_txn(1, 0, 0, 0, 0, -1, -1);
    @(negedge clk);
    vsync = 1;
    repeat (4) @(negedge clk);
    vsync = 0;
    repeat (2) @(negedge clk);
    m_vidadr = 0;
    run_txn(1, 0, 0, 0, 0, -1, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_video();
    test_arbitration();
    test_fill();
    test_wrap();
    test_random();
    test_err();
    test_reset_mid_xfer();
`ifdef VID_FRAME_SYNC_EN
    test_frame_sync();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
